// File: rtl/rx_sample_packer_pkg.sv
// Shared constants and helpers for the RX sample packer.
// Optional build macro: RX_PACK8_EN (one packed 8+8-bit word per sample).
package rx_sample_packer_pkg;

  localparam int RX_WORD_W         = 16;
  localparam int RX_DEPTH_LOG2_DEF = 9;
  localparam int RX_PKT_WORDS_DEF  = 256;

`ifdef RX_PACK8_EN
  // A packed sample occupies a single word.
  localparam int RX_FREE_MIN = 1;
`else
  // An I/Q pair occupies two words and must land whole.
  localparam int RX_FREE_MIN = 2;
`endif

  // Keep only the top byte of each component; plain truncation.
  function automatic logic [RX_WORD_W-1:0] rx_pack8(input logic [RX_WORD_W-1:0] i_s,
                                                    input logic [RX_WORD_W-1:0] q_s);
    return {i_s[RX_WORD_W-1 -: 8], q_s[RX_WORD_W-1 -: 8]};
  endfunction

endpackage

// File: rtl/rx_sample_packer_fifo.sv
// Single-clock word FIFO with registered read port and exact level count.
// Pops on an empty FIFO are ignored; writes are never issued when full.
module rx_sample_packer_fifo
  import rx_sample_packer_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_DEPTH_LOG2_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [RX_WORD_W-1:0]  wr_data,
  input  logic                  rd_en,
  output logic [RX_WORD_W-1:0]  rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic [DEPTH_LOG2:0]   level_nxt
);

  localparam int LW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [RX_WORD_W-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [RX_WORD_W-1:0]  rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  pop;

  // Next-state for pointers, level and the registered read word.
  always_comb begin
    pop        = rd_en && (level_q != '0);
    wr_ptr_d   = wr_en ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    level_d    = level_q + LW'(wr_en) - LW'(pop);
    rd_valid_d = pop;
    rd_data_d  = pop ? mem[rd_ptr_q] : rd_data_q;
  end

  // Storage array; contents are don't-care after reset since pointers clear.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  // Pointer, level and read-port registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign level     = level_q;
  assign level_nxt = level_d;

endmodule

// File: rtl/rx_sample_packer.sv
// Packs halfband-strobed I/Q samples into a 16-bit word FIFO (I then Q),
// dropping whole samples on lack of space or too-close strobes, with a
// sticky overrun flag and a registered packet-ready flag.
// Optional build macro: RX_PACK8_EN (one {I[15:8],Q[15:8]} word per sample).
module rx_sample_packer
  import rx_sample_packer_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_DEPTH_LOG2_DEF,
  parameter int PKT_WORDS  = RX_PKT_WORDS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 strobe_in,
  input  logic [RX_WORD_W-1:0] i_in,
  input  logic [RX_WORD_W-1:0] q_in,
  input  logic                 rd_req,
  output logic [RX_WORD_W-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 have_pkt,
  output logic [DEPTH_LOG2:0]  level,
  output logic                 overrun,
  input  logic                 clear_status
);

  localparam int            LW      = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_W = LW'(2 ** DEPTH_LOG2);

  logic [LW-1:0]        fifo_level, fifo_level_nxt, free_words;
  logic                 wr_en;
  logic [RX_WORD_W-1:0] wr_data;
  logic                 new_sample, drop;
  logic                 overrun_q, overrun_d;
  logic                 have_pkt_q, have_pkt_d;

`ifndef RX_PACK8_EN
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_Q_PEND = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [RX_WORD_W-1:0] q_hold_q, q_hold_d;
`endif

  // Write sequencer, drop decision and status next-state.
  always_comb begin
    new_sample = strobe_in && enable;
    // Space is judged on the level before this cycle's pop.
    free_words = DEPTH_W - fifo_level;
    wr_en      = 1'b0;
    wr_data    = i_in;
    drop       = 1'b0;
`ifdef RX_PACK8_EN
    wr_data = rx_pack8(i_in, q_in);
    if (new_sample) begin
      if (free_words >= LW'(RX_FREE_MIN)) wr_en = 1'b1;
      else                                drop  = 1'b1;
    end
`else
    state_d  = state_q;
    q_hold_d = q_hold_q;
    if (state_q == ST_Q_PEND) begin
      // Q always completes, even if enable dropped, so pairs stay aligned.
      wr_en   = 1'b1;
      wr_data = q_hold_q;
      state_d = ST_IDLE;
      drop    = new_sample;
    end else if (new_sample) begin
      if (free_words >= LW'(RX_FREE_MIN)) begin
        wr_en    = 1'b1;
        q_hold_d = q_in;
        state_d  = ST_Q_PEND;
      end else begin
        drop = 1'b1;
      end
    end
`endif
    // A drop in the same cycle as clear_status leaves the flag set.
    if (drop)              overrun_d = 1'b1;
    else if (clear_status) overrun_d = 1'b0;
    else                   overrun_d = overrun_q;
    have_pkt_d = (fifo_level_nxt >= LW'(PKT_WORDS));
  end

  // Control and flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q  <= 1'b0;
      have_pkt_q <= 1'b0;
`ifndef RX_PACK8_EN
      state_q    <= ST_IDLE;
`endif
    end else begin
      overrun_q  <= overrun_d;
      have_pkt_q <= have_pkt_d;
`ifndef RX_PACK8_EN
      state_q    <= state_d;
`endif
    end
  end

`ifndef RX_PACK8_EN
  // Held Q component; validity is tracked by the sequencer state.
  always_ff @(posedge clock) begin
    q_hold_q <= q_hold_d;
  end
`endif

  rx_sample_packer_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .level     (fifo_level),
    .level_nxt (fifo_level_nxt)
  );

  assign level    = fifo_level;
  assign have_pkt = have_pkt_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_rx_sample_packer.sv
// Directed and random bench for rx_sample_packer against a queue-based model.
module tb_rx_sample_packer;

  localparam int DL    = 9;
  localparam int DEPTH = 512;
  localparam int PKT   = 256;

  logic        clock = 1'b0;
  logic        reset, enable, strobe_in, rd_req, clear_status;
  logic [15:0] i_in, q_in, rd_data;
  logic        rd_valid, have_pkt, overrun;
  logic [DL:0] level;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] mq[$];
  bit          m_pend;
  logic [15:0] m_hold;
  bit          m_ov;
  bit          m_rv;
  logic [15:0] m_rd;

  rx_sample_packer #(.DEPTH_LOG2(DL), .PKT_WORDS(PKT)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .strobe_in    (strobe_in),
    .i_in         (i_in),
    .q_in         (q_in),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .have_pkt     (have_pkt),
    .level        (level),
    .overrun      (overrun),
    .clear_status (clear_status)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the rules to the current inputs for one clock.
  task automatic model_step();
    int lvl;
    bit drop;
    bit pop;
    if (reset) begin
      mq.delete();
      m_pend = 0;
      m_ov   = 0;
      m_rv   = 0;
      m_rd   = '0;
    end else begin
      lvl  = mq.size();
      drop = 0;
      pop  = rd_req && (lvl > 0);
      m_rv = pop;
      if (pop) m_rd = mq.pop_front();
`ifdef RX_PACK8_EN
      if (strobe_in && enable) begin
        if (DEPTH - lvl >= 1) mq.push_back({i_in[15:8], q_in[15:8]});
        else drop = 1;
      end
`else
      if (m_pend) begin
        mq.push_back(m_hold);
        m_pend = 0;
        if (strobe_in && enable) drop = 1;
      end else if (strobe_in && enable) begin
        if (DEPTH - lvl >= 2) begin
          mq.push_back(i_in);
          m_hold = q_in;
          m_pend = 1;
        end else begin
          drop = 1;
        end
      end
`endif
      if (drop) m_ov = 1;
      else if (clear_status) m_ov = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("rd_valid", rd_valid, m_rv);
    chk("rd_data",  rd_data,  m_rd);
    chk("level",    level,    mq.size());
    chk("have_pkt", have_pkt, mq.size() >= PKT);
    chk("overrun",  overrun,  m_ov);
  endtask

  task automatic cyc(input bit s, input logic [15:0] i, input logic [15:0] q, input bit rd);
    strobe_in = s;
    i_in      = i;
    q_in      = q;
    rd_req    = rd;
    tick();
    strobe_in = 1'b0;
    rd_req    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; strobe_in = 1'b0; rd_req = 1'b0;
    clear_status = 1'b0; i_in = '0; q_in = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_level", level, 0);
    chk("reset_rd_valid", rd_valid, 0);

`ifndef RX_PACK8_EN
    // T1: three spaced samples then six pops
    for (int k = 0; k < 3; k++) begin
      cyc(1, 16'h1234, 16'hABCD, 0);
      for (int j = 0; j < 3; j++) cyc(0, 0, 0, 0);
    end
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("t1_level", level, 0);
    chk("t1_last_word", rd_data, 16'hABCD);

    // T2: 128 samples reach the packet threshold
    for (int k = 0; k < 128; k++) begin
      cyc(1, 16'($urandom), 16'($urandom), 0);
      cyc(0, 0, 0, 0);
    end
    chk("t2_have_pkt_set", have_pkt, 1);
    cyc(0, 0, 0, 1);
    chk("t2_have_pkt_clr", have_pkt, 0);

    // T3: 511 words, then a sample that cannot fit
    for (int k = 0; k < 128; k++) begin
      cyc(1, 16'($urandom), 16'($urandom), 0);
      cyc(0, 0, 0, 0);
    end
    chk("t3_level511", level, 511);
    cyc(1, 16'h5555, 16'h6666, 0);
    cyc(0, 0, 0, 0);
    chk("t3_drop_level", level, 511);
    chk("t3_drop_overrun", overrun, 1);
    clear_status = 1'b1;
    cyc(0, 0, 0, 0);
    clear_status = 1'b0;
    chk("t3_cleared", overrun, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 16'h7777, 16'h8888, 0);
    cyc(0, 0, 0, 0);
    chk("t3_full", level, 512);
    chk("t3_no_overrun", overrun, 0);
    // drop and clear together: set wins
    clear_status = 1'b1;
    cyc(1, 16'h9999, 16'hAAAA, 0);
    clear_status = 1'b0;
    chk("t3_set_wins", overrun, 1);
    for (int k = 0; k < 515; k++) cyc(0, 0, 0, 1);
    chk("t3_drained", level, 0);

    // T4: strobes one cycle apart
    clear_status = 1'b1;
    cyc(0, 0, 0, 0);
    clear_status = 1'b0;
    cyc(1, 16'h0001, 16'h0002, 0);
    cyc(1, 16'h0003, 16'h0004, 0);
    cyc(0, 0, 0, 0);
    chk("t4_level", level, 2);
    chk("t4_overrun", overrun, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1);

    // enable falls while Q is pending: Q still written
    cyc(1, 16'h0005, 16'h0006, 0);
    enable = 1'b0;
    cyc(1, 16'h00EE, 16'h00FF, 0);
    enable = 1'b1;
    chk("en_fall_level", level, 2);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1);

    // T5: reset with Q pending and a read request
    cyc(1, 16'hAAAA, 16'hBBBB, 0);
    reset = 1'b1;
    cyc(0, 0, 0, 1);
    reset = 1'b0;
    chk("t5_level", level, 0);
    chk("t5_rd_valid", rd_valid, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0);
    chk("t5_no_q", level, 0);
`else
    // T6: packed single word, back-to-back accepted
    cyc(1, 16'h7F80, 16'h8001, 0);
    chk("t6_level1", level, 1);
    cyc(1, 16'h1234, 16'hABCD, 0);
    chk("t6_level2", level, 2);
    chk("t6_no_overrun", overrun, 0);
    cyc(0, 0, 0, 1);
    chk("t6_word", rd_data, 16'h7F80);
    cyc(0, 0, 0, 1);
    chk("t6_word2", rd_data, 16'h12AB);
`endif

    // Random traffic, slow reader so the FIFO fills and overflows
    for (int k = 0; k < 3000; k++) begin
      enable       = ($urandom_range(0, 15) != 0);
      clear_status = ($urandom_range(0, 31) == 0);
      cyc($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom), $urandom_range(0, 4) == 0);
    end
    enable       = 1'b1;
    clear_status = 1'b0;
    for (int k = 0; k < 530; k++) cyc(0, 0, 0, 1);
    chk("final_empty", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
